// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO and its UART drain stage.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: one tick per CLK_DIV cycles while run is high.
// The count is held at zero whenever run is low, so each rise of run starts a fresh period.
module baud_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt;

  // tick_next looks one cycle ahead so tick itself can come straight from a flop
  assign tick_next = run && (cnt == PRE);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= tick_next;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame and shifts it out as start, data LSB first,
// optional parity and stop bits.
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int CLK_DIV    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty_n,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int MAXB = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_t        state, state_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             parity_q, parity_next;
  logic             tx_next;
  logic             run, tick, tick_next;

  assign run  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign busy = (state != IDLE);

  baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    parity_next  = parity_q;
    case (state)
      IDLE:   if (tx_en && fifo_empty_n) state_next = POP;
      POP:    state_next = LOAD;
      LOAD: begin
        shreg_next   = fifo_data;
        parity_next  = (^fifo_data) ^ (PARITY_ODD != 0);
        bit_cnt_next = '0;
        state_next   = START;
      end
      START:  if (tick) state_next = DATA;
      DATA: begin
        if (tick) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_next = '0;
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: if (tick) state_next = STOP;
      STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line value is chosen from the next state so the tx flop lines up with the FSM
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_q   <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      shreg      <= shreg_next;
      parity_q   <= parity_next;
      tx         <= tx_next;
      fifo_rd_en <= (state_next == POP);
      frame_done <= (state == STOP) && (bit_cnt == LAST_STOP) && tick_next;
    end
  end

endmodule
